threshold_param: RTL and testbench

- Parametrised multi-level threshold stage for the RGB pixel stream; a successor to the fixed 24-bit / 4-level threshold block.
- Generalises channel count, channel width and number of levels, and adds per-channel modes (binary, band, quantize, bypass).
- Configuration writes are staged in shadow registers and committed only at frame boundaries, so one frame is never processed with mixed settings.
- Sits between pixel source and image writer: stream in, stream out, fixed latency.

---
 rtl/threshold_param.sv | 194 +++++++++++++++++++
 tb/tb_threshold_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_param.sv
// Parametrised multi-level threshold stage for a CH x CW pixel stream.
// Shadow config is committed whenever the position counters sit at (0,0).
module threshold_param #(
  parameter int CH    = 3,
  parameter int CW    = 8,
  parameter int NLVL  = 4,
  parameter int RES_W = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [CH*CW-1:0]        d_in,
  input  logic                    d_in_vld,
  output logic [CH*CW-1:0]        d_out,
  output logic                    d_out_vld,
  output logic                    frame_end,
  input  logic [RES_W-1:0]        input_res_x,
  input  logic [RES_W-1:0]        input_res_y,
  input  logic                    cfg_we,
  input  logic [$clog2(NLVL)-1:0] cfg_addr,
  input  logic [CH-1:0]           cfg_ch,
  input  logic [CH*CW-1:0]        cfg_val,
  input  logic [2*CH-1:0]         cfg_mode
);

  localparam int LW = $clog2(NLVL);
  localparam int SH = CW - LW;
  localparam logic [CW-1:0]    M   = '1;
  localparam logic [RES_W-1:0] ONE = RES_W'(1);
  localparam logic [1:0] BIN  = 2'd0;
  localparam logic [1:0] BAND = 2'd1;
  localparam logic [1:0] QNT  = 2'd2;
  localparam logic [1:0] BYP  = 2'd3;

  typedef logic [CH-1:0][NLVL-1:0][CW-1:0] thr_t;
  typedef logic [CH-1:0][1:0] mode_t;

  thr_t  sh_t_q, sh_t_d, act_t_q, act_t_d;
  mode_t sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [RES_W-1:0] x_q, x_d, y_q, y_d;
  logic [RES_W-1:0] rx_q, rx_d, ry_q, ry_d;
  logic fe_tag, commit;

  logic [CH-1:0][NLVL-1:0] s1_ge_q, s1_ge_d;
  logic [CH-1:0]           s1_le_q, s1_le_d;
  logic [CH*CW-1:0]        s1_p_q, s1_p_d;
  mode_t                   s1_mode_q, s1_mode_d;
  logic s1_vld_q, s1_vld_d, s1_fe_q, s1_fe_d;

  logic [CH*CW-1:0] out_q, out_d;
  logic vld_q, vld_d, fe_q, fe_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    fe_tag = 1'b0;
    if (d_in_vld) begin
      if (x_q == rx_q - ONE) begin
        x_d = '0;
        if (y_q == ry_q - ONE) begin
          y_d    = '0;
          fe_tag = 1'b1;
        end else begin
          y_d = y_q + ONE;
        end
      end else begin
        x_d = x_q + ONE;
      end
    end
    commit = (x_d == '0) && (y_d == '0);
  end

  always_comb begin
    sh_t_d    = sh_t_q;
    sh_mode_d = sh_mode_q;
    if (cfg_we) begin
      for (int c = 0; c < CH; c++) begin
        if (cfg_ch[c]) begin
          sh_t_d[c][cfg_addr] = cfg_val[c*CW +: CW];
          sh_mode_d[c]        = cfg_mode[c*2 +: 2];
        end
      end
    end
  end

  // Commit samples the shadow copy before this cycle's write lands.
  always_comb begin
    act_t_d    = act_t_q;
    act_mode_d = act_mode_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    if (commit) begin
      act_t_d    = sh_t_q;
      act_mode_d = sh_mode_q;
      rx_d       = (input_res_x == '0) ? ONE : input_res_x;
      ry_d       = (input_res_y == '0) ? ONE : input_res_y;
    end
  end

  always_comb begin
    logic [CW-1:0] p;
    p         = '0;
    s1_ge_d   = '0;
    s1_le_d   = '0;
    s1_p_d    = d_in;
    s1_mode_d = act_mode_q;
    s1_vld_d  = d_in_vld;
    s1_fe_d   = fe_tag;
    for (int c = 0; c < CH; c++) begin
      p = d_in[c*CW +: CW];
      for (int k = 0; k < NLVL; k++)
        s1_ge_d[c][k] = p >= act_t_q[c][k];
      s1_le_d[c] = p <= act_t_q[c][1];
    end
  end

  always_comb begin
    logic [CW-1:0] p;
    logic [CW-1:0] o;
    logic [CW-1:0] qv;
    logic [LW:0]   cnt;
    p     = '0;
    o     = '0;
    qv    = '0;
    cnt   = '0;
    out_d = '0;
    vld_d = s1_vld_q;
    fe_d  = s1_fe_q;
    for (int c = 0; c < CH; c++) begin
      p   = s1_p_q[c*CW +: CW];
      cnt = '0;
      for (int k = 0; k < NLVL; k++)
        cnt = cnt + (LW+1)'(s1_ge_q[c][k]);
      qv = CW'(cnt) << SH;
      unique case (1'b1)
        (s1_mode_q[c] == BIN):
          o = s1_ge_q[c][0] ? M : '0;
        (s1_mode_q[c] == BAND):
          o = (s1_ge_q[c][0] && s1_le_q[c]) ? p : '0;
        (s1_mode_q[c] == QNT):
          o = (cnt == (LW+1)'(NLVL)) ? M : qv;
        (s1_mode_q[c] == BYP):
          o = p;
        default:
          o = p;
      endcase
      out_d[c*CW +: CW] = o;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      sh_t_q     <= '0;
      act_t_q    <= '0;
      sh_mode_q  <= {CH{BYP}};
      act_mode_q <= {CH{BYP}};
      x_q        <= '0;
      y_q        <= '0;
      rx_q       <= ONE;
      ry_q       <= ONE;
      s1_ge_q    <= '0;
      s1_le_q    <= '0;
      s1_p_q     <= '0;
      s1_mode_q  <= {CH{BYP}};
      s1_vld_q   <= 1'b0;
      s1_fe_q    <= 1'b0;
      out_q      <= '0;
      vld_q      <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      sh_t_q     <= sh_t_d;
      act_t_q    <= act_t_d;
      sh_mode_q  <= sh_mode_d;
      act_mode_q <= act_mode_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      s1_ge_q    <= s1_ge_d;
      s1_le_q    <= s1_le_d;
      s1_p_q     <= s1_p_d;
      s1_mode_q  <= s1_mode_d;
      s1_vld_q   <= s1_vld_d;
      s1_fe_q    <= s1_fe_d;
      out_q      <= out_d;
      vld_q      <= vld_d;
      fe_q       <= fe_d;
    end
  end

  assign d_out     = out_q;
  assign d_out_vld = vld_q;
  assign frame_end = fe_q;

endmodule

// File: tb/tb_threshold_param.sv
// Scoreboard bench for threshold_param: directed frames, queued expectations,
// independent output monitor checking data, frame_end and 2-cycle latency.
module tb_threshold_param;

  logic        clk;
  logic        resetn;
  logic [23:0] d_in;
  logic        d_in_vld;
  logic [23:0] d_out;
  logic        d_out_vld;
  logic        frame_end;
  logic [15:0] input_res_x;
  logic [15:0] input_res_y;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [2:0]  cfg_ch;
  logic [23:0] cfg_val;
  logic [5:0]  cfg_mode;

  typedef struct {
    logic [23:0] d;
    logic        fe;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  threshold_param dut (
    .clk        (clk),
    .resetn     (resetn),
    .d_in       (d_in),
    .d_in_vld   (d_in_vld),
    .d_out      (d_out),
    .d_out_vld  (d_out_vld),
    .frame_end  (frame_end),
    .input_res_x(input_res_x),
    .input_res_y(input_res_y),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_ch     (cfg_ch),
    .cfg_val    (cfg_val),
    .cfg_mode   (cfg_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (d_out_vld) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got d_out=%06h fe=%0b with nothing expected",
                 d_out, frame_end);
      end else begin
        e = sb.pop_front();
        if (d_out !== e.d || frame_end !== e.fe || cyc != e.cyc)
          begin
            errors++;
            $display("FAIL pixel_out: got d_out=%06h fe=%0b cyc=%0d, expected d_out=%06h fe=%0b cyc=%0d",
                     d_out, frame_end, cyc, e.d, e.fe, e.cyc);
          end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic idle(input int n);
    d_in_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] px, input logic [23:0] ex,
                      input logic fe, input bit push);
    d_in     = px;
    d_in_vld = 1'b1;
    if (push) sb.push_back('{ex, fe, cyc + 2});
    @(posedge clk);
    #1;
    d_in_vld = 1'b0;
  endtask

  task automatic cfg_set(input logic [1:0] a, input logic [2:0] ch,
                         input logic [23:0] v, input logic [5:0] m);
    cfg_addr = a;
    cfg_ch   = ch;
    cfg_val  = v;
    cfg_mode = m;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [2:0] ch,
                        input logic [23:0] v, input logic [5:0] m);
    cfg_set(a, ch, v, m);
    cfg_we = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  logic [23:0] t1_px [6];
  int          wait_cnt;

  initial begin
    checks      = 0;
    errors      = 0;
    resetn      = 1'b1;
    d_in        = '0;
    d_in_vld    = 1'b0;
    input_res_x = 16'd4;
    input_res_y = 16'd2;
    cfg_we      = 1'b0;
    cfg_set(2'd0, 3'b000, 24'h0, 6'h0);
    t1_px = '{24'h000000, 24'hFFFFFF, 24'hA5A5A5,
              24'h010203, 24'h7F8081, 24'hC0FFEE};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_out", 32'(d_out), 32'h0);
    chk("rst_vld", 32'(d_out_vld), 32'h0);
    chk("rst_fe", 32'(frame_end), 32'h0);
    resetn = 1'b0;
    idle(2);

    // bypass, 4x2 frame
    send(24'h123456, 24'h123456, 1'b0, 1'b1);
    send(24'h123456, 24'h123456, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      send(t1_px[i], t1_px[i], 1'(i == 5), 1'b1);

    // binary, 2x1
    input_res_x = 16'd2;
    input_res_y = 16'd1;
    cfg_wr(2'd0, 3'b111, 24'h808080, 6'b000000);
    idle(2);
    send(24'h7F80FF, 24'h00FFFF, 1'b0, 1'b1);
    send(24'h000081, 24'h0000FF, 1'b1, 1'b1);

    // quantize
    cfg_wr(2'd0, 3'b111, 24'h202020, 6'b101010);
    cfg_wr(2'd1, 3'b111, 24'h606060, 6'b101010);
    cfg_wr(2'd2, 3'b111, 24'hA0A0A0, 6'b101010);
    cfg_wr(2'd3, 3'b111, 24'hE0E0E0, 6'b101010);
    idle(2);
    send(24'h901F00, 24'h800000, 1'b0, 1'b1);
    send(24'hE0FF60, 24'hFFFF80, 1'b1, 1'b1);

    // band on R, then inverted band
    cfg_wr(2'd0, 3'b111, 24'h404040, 6'b011111);
    cfg_wr(2'd1, 3'b100, 24'h800000, 6'b011111);
    idle(2);
    send(24'h505050, 24'h505050, 1'b0, 1'b1);
    send(24'h905050, 24'h005050, 1'b1, 1'b1);
    cfg_wr(2'd0, 3'b100, 24'h800000, 6'b011111);
    cfg_wr(2'd1, 3'b100, 24'h400000, 6'b011111);
    idle(2);
    send(24'h505050, 24'h005050, 1'b0, 1'b1);
    send(24'h80A0B0, 24'h00A0B0, 1'b1, 1'b1);

    // mid-frame write only lands at the next frame
    input_res_x = 16'd4;
    cfg_wr(2'd0, 3'b111, 24'h808080, 6'b000000);
    idle(2);
    send(24'h904040, 24'hFF0000, 1'b0, 1'b1);
    send(24'h404040, 24'h000000, 1'b0, 1'b1);
    cfg_set(2'd0, 3'b111, 24'h101010, 6'b000000);
    cfg_we = 1'b1;
    send(24'h404040, 24'h000000, 1'b0, 1'b1);
    cfg_we = 1'b0;
    send(24'h404040, 24'h000000, 1'b1, 1'b1);
    send(24'h404040, 24'hFFFFFF, 1'b0, 1'b1);
    idle(3);

    // reset with two pixels in flight
    send(24'h111111, 24'h0, 1'b0, 1'b0);
    send(24'h222222, 24'h0, 1'b0, 1'b0);
    chk("inflight_vld", 32'(d_out_vld), 32'h1);
    resetn = 1'b1;
    #1;
    chk("rst_async_vld", 32'(d_out_vld), 32'h0);
    chk("rst_async_d_out", 32'(d_out), 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    idle(1);
    send(24'h404040, 24'h404040, 1'b0, 1'b1);
    send(24'hABCDEF, 24'hABCDEF, 1'b0, 1'b1);
    send(24'h0F0F0F, 24'h0F0F0F, 1'b0, 1'b1);
    send(24'hF0F0F0, 24'hF0F0F0, 1'b1, 1'b1);

    // zero resolution behaves as 1x1
    input_res_x = 16'd0;
    input_res_y = 16'd0;
    idle(2);
    send(24'h123456, 24'h123456, 1'b1, 1'b1);
    send(24'h654321, 24'h654321, 1'b1, 1'b1);

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
